// File: rtl/ps2_host_tx_if.sv
// -----------------------------------------------------------------------------
// ps2_host_tx_if
// Bundle between a command issuer and the PS/2 host transmitter.
//   tx_data/tx_start        : command byte and one-cycle send request
//   tx_busy/tx_done/tx_err  : transfer status (done/err are one-cycle pulses)
//   ps2_clk_i/ps2_data_i    : raw PS/2 line levels seen at the pads
//   ps2_clk_oe/ps2_data_oe  : active-high pull-low enables for the pads
// master = issuer/pad side, slave = transmitter.
// -----------------------------------------------------------------------------
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_err;
   logic       ps2_clk_i;
   logic       ps2_data_i;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;

   modport master (
      output tx_data, tx_start, ps2_clk_i, ps2_data_i,
      input  tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
   );

   modport slave (
      input  tx_data, tx_start, ps2_clk_i, ps2_data_i,
      output tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe
   );
endinterface

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 command transmitter (request-to-send, device-clocked).
// Sends one byte as start, D0..D7, odd parity, stop, then reads the device
// ACK bit and waits for both lines to return high.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset; releases both lines at once
//   bus  : ps2_host_tx_if.slave
//          tx_data/tx_start  in  : byte + request (accepted only when idle)
//          tx_busy           out : high from cycle after accept to done cycle
//          tx_done/tx_err    out : one-cycle completion pulse, err = NACK/timeout
//          ps2_clk_i/data_i  in  : raw line levels (synchronised here)
//          ps2_clk_oe/data_oe out: 1 = pull line low
// -----------------------------------------------------------------------------
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned RTS_CYCLES     = 50,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic          clk,
   input  logic          rst,
   ps2_host_tx_if.slave  bus
);

   localparam int unsigned CMAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
   localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_IDLE
   } state_t;

   state_t      r_state, w_state_nxt;

   // line synchronisers; reset to the idle-high level so no false fall
   logic        r_clk_m, r_clk_s, r_clk_prev;
   logic        r_data_m, r_data_s;

   logic [9:0]    r_sr;
   logic [3:0]    r_bitcnt;
   logic [CW-1:0] r_cnt;
   logic [TW-1:0] r_tocnt;
   logic          r_ack_bad;

   logic r_clk_oe, r_data_oe, r_busy, r_done, r_err;
   logic w_clk_oe_nxt, w_data_oe_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;

   logic w_fall, w_idle, w_timeout, w_inh_end, w_rts_end;

   // ---------------------------------------------------------------- sync
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_m    <= 1'b1;
         r_clk_s    <= 1'b1;
         r_clk_prev <= 1'b1;
         r_data_m   <= 1'b1;
         r_data_s   <= 1'b1;
      end else begin
         r_clk_m    <= bus.ps2_clk_i;
         r_clk_s    <= r_clk_m;
         r_clk_prev <= r_clk_s;
         r_data_m   <= bus.ps2_data_i;
         r_data_s   <= r_data_m;
      end
   end

   assign w_fall    = r_clk_prev & ~r_clk_s;
   assign w_idle    = r_clk_s & r_data_s;
   assign w_timeout = (r_tocnt == TO_LAST);
   assign w_inh_end = (r_state == S_INHIBIT) && (r_cnt == INH_LAST);
   assign w_rts_end = (r_state == S_RTS) && (r_cnt == RTS_LAST);

   // ------------------------------------------------------ state register
   // Outputs are registered alongside the state so the pad enables never
   // glitch; reset clears them asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_clk_oe  <= w_clk_oe_nxt;
         r_data_oe <= w_data_oe_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
      end
   end

   // ---------------------------------------------------------- next state
   // Timeout is tested first in every timed state so it wins over a
   // coincident fall or idle detect.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:      if (bus.tx_start) w_state_nxt = S_INHIBIT;
         S_INHIBIT:   if (w_inh_end)    w_state_nxt = S_RTS;
         S_RTS:       if (w_rts_end)    w_state_nxt = S_SHIFT;
         S_SHIFT: begin
            if (w_timeout)                         w_state_nxt = S_IDLE;
            else if (w_fall && r_bitcnt == 4'd9)   w_state_nxt = S_ACK;
         end
         S_ACK: begin
            if (w_timeout)   w_state_nxt = S_IDLE;
            else if (w_fall) w_state_nxt = S_WAIT_IDLE;
         end
         S_WAIT_IDLE: if (w_timeout || w_idle) w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------- outputs
   // Next values of the registered outputs; the line enables hold unless
   // a state event changes them.
   always_comb begin
      w_clk_oe_nxt  = r_clk_oe;
      w_data_oe_nxt = r_data_oe;
      w_done_nxt    = 1'b0;
      w_err_nxt     = 1'b0;
      w_busy_nxt    = (w_state_nxt != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (bus.tx_start) begin
               w_clk_oe_nxt  = 1'b1;
               w_data_oe_nxt = 1'b0;
            end
         end
         S_INHIBIT: if (w_inh_end) w_data_oe_nxt = 1'b1;   // start bit
         S_RTS:     if (w_rts_end) w_clk_oe_nxt  = 1'b0;   // hand clock to device
         S_SHIFT: begin
            if (w_timeout) begin
               w_clk_oe_nxt  = 1'b0;
               w_data_oe_nxt = 1'b0;
               w_done_nxt    = 1'b1;
               w_err_nxt     = 1'b1;
            end else if (w_fall) begin
               // pull low for a 0 bit; stop bit (1) releases the line
               w_data_oe_nxt = ~r_sr[0];
            end
         end
         S_ACK, S_WAIT_IDLE: begin
            if (w_timeout) begin
               w_clk_oe_nxt  = 1'b0;
               w_data_oe_nxt = 1'b0;
               w_done_nxt    = 1'b1;
               w_err_nxt     = 1'b1;
            end else if (r_state == S_WAIT_IDLE && w_idle) begin
               w_done_nxt = 1'b1;
               w_err_nxt  = r_ack_bad;
            end
         end
         default: begin
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sr      <= '0;
         r_bitcnt  <= '0;
         r_cnt     <= '0;
         r_tocnt   <= '0;
         r_ack_bad <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt   <= '0;
               r_tocnt <= '0;
               if (bus.tx_start) begin
                  // stop, odd parity, data; shifted out LSB first
                  r_sr      <= {1'b1, ~^bus.tx_data, bus.tx_data};
                  r_bitcnt  <= '0;
                  r_ack_bad <= 1'b0;
               end
            end
            S_INHIBIT: r_cnt <= w_inh_end ? '0 : r_cnt + 1'b1;
            S_RTS: begin
               if (w_rts_end) begin
                  r_cnt    <= '0;
                  r_bitcnt <= '0;
                  r_tocnt  <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_SHIFT, S_ACK, S_WAIT_IDLE: begin
               r_tocnt <= w_timeout ? '0 : r_tocnt + 1'b1;
               if (!w_timeout && w_fall) begin
                  if (r_state == S_SHIFT) begin
                     r_sr     <= {1'b0, r_sr[9:1]};
                     r_bitcnt <= r_bitcnt + 4'd1;
                  end
                  if (r_state == S_ACK)
                     r_ack_bad <= r_data_s;   // device holds data low to ACK
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ps2_clk_oe  = r_clk_oe;
   assign bus.ps2_data_oe = r_data_oe;
   assign bus.tx_busy     = r_busy;
   assign bus.tx_done     = r_done;
   assign bus.tx_err      = r_err;

endmodule
